iq_deinterleave: RTL

Parametrised successor to the FM-radio front-end IQ reader. Pops raw bytes from the input byte FIFO, assembles an I and a Q sample of configurable byte width, endianness and I/Q order, sign-extends and quantizes them, and writes each pair to the I and Q output FIFOs together. A one-pair output register lets byte assembly continue while the output FIFOs apply backpressure. A pair counter gives the downstream demodulator and the testbench a sample index.

---
 rtl/iq_pkg.sv | 23 ++
 rtl/iq_sample_assembler.sv | 63 ++++++
 rtl/iq_deinterleave.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/iq_pkg.sv
// -----------------------------------------------------------------------------
// iq_pkg
// Shared definitions for the IQ front end and the demodulator blocks.
//   state_t           : byte-collection FSM states (first / second component)
//   DEFAULT_BYTE      : width of one raw input FIFO word
//   DEFAULT_SAMPLE_BYTES : bytes per I or Q sample
//   DEFAULT_DATA_SIZE : width of a quantized sample
//   DEFAULT_BITS      : fixed-point fraction bits (quantization left shift)
// No ports; constants and types only.
// -----------------------------------------------------------------------------
package iq_pkg;

    typedef enum logic {
        S_FIRST  = 1'b0,
        S_SECOND = 1'b1
    } state_t;

    localparam int DEFAULT_BYTE         = 8;
    localparam int DEFAULT_SAMPLE_BYTES = 2;
    localparam int DEFAULT_DATA_SIZE    = 32;
    localparam int DEFAULT_BITS         = 10;

endpackage

// File: rtl/iq_sample_assembler.sv
// -----------------------------------------------------------------------------
// iq_sample_assembler
// Collects the bytes of one component (I or Q) into a raw two's complement
// word and presents it sign-extended and shifted left by BITS.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   load_i        : a byte of this component is being popped this cycle
//   byte_idx_i    : index of that byte within the component
//   data_i        : the popped byte
//   sample_o      : quantized sample, including the byte being loaded now,
//                   so the top can capture a complete pair on the final pop
// -----------------------------------------------------------------------------
module iq_sample_assembler #(
    parameter int BYTE          = 8,
    parameter int SAMPLE_BYTES  = 2,
    parameter int DATA_SIZE     = 32,
    parameter int BITS          = 10,
    parameter int LITTLE_ENDIAN = 1,
    parameter int IDX_W         = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        load_i,
    input  logic [IDX_W-1:0]            byte_idx_i,
    input  logic [BYTE-1:0]             data_i,
    output logic signed [DATA_SIZE-1:0] sample_o
);

    localparam int W = SAMPLE_BYTES * BYTE;

    logic [W-1:0]                raw_q;
    logic [W-1:0]                raw_d;
    logic [IDX_W-1:0]            bytePos;
    logic signed [W-1:0]         rawSigned;
    logic signed [DATA_SIZE-1:0] rawExtended;

    // Place the incoming byte by endianness; all other bytes keep their value
    always_comb begin
        raw_d = raw_q;
        if (LITTLE_ENDIAN != 0) begin
            bytePos = byte_idx_i;
        end else begin
            bytePos = IDX_W'(SAMPLE_BYTES - 1) - byte_idx_i;
        end
        if (load_i) begin
            raw_d[int'(bytePos) * BYTE +: BYTE] = data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            raw_q <= '0;
        end else begin
            raw_q <= raw_d;
        end
    end

    // Sized cast of a signed value sign-extends before the quantization shift
    assign rawSigned   = raw_d;
    assign rawExtended = DATA_SIZE'(rawSigned);
    assign sample_o    = rawExtended <<< BITS;

endmodule

// File: rtl/iq_deinterleave.sv
// -----------------------------------------------------------------------------
// iq_deinterleave
// Pops raw bytes from a first-word-fall-through FIFO, assembles an I/Q pair
// and pushes it into the I and Q output FIFOs together.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   in_empty       : input FIFO empty
//   in_rd_en       : pop input FIFO (data_in valid whenever in_empty = 0)
//   data_in        : input FIFO head
//   i_out_full     : I output FIFO full
//   q_out_full     : Q output FIFO full
//   out_wr_en      : push i_out / q_out into both output FIFOs
//   i_out, q_out   : registered quantized samples
//   sample_count   : pairs written since reset, wraps
// -----------------------------------------------------------------------------
module iq_deinterleave
    import iq_pkg::*;
#(
    parameter int BYTE          = DEFAULT_BYTE,
    parameter int SAMPLE_BYTES  = DEFAULT_SAMPLE_BYTES,
    parameter int DATA_SIZE     = DEFAULT_DATA_SIZE,
    parameter int BITS          = DEFAULT_BITS,
    parameter int LITTLE_ENDIAN = 1,
    parameter int Q_FIRST       = 0,
    parameter int COUNT_WIDTH   = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_empty,
    output logic                        in_rd_en,
    input  logic [BYTE-1:0]             data_in,
    input  logic                        i_out_full,
    input  logic                        q_out_full,
    output logic                        out_wr_en,
    output logic signed [DATA_SIZE-1:0] i_out,
    output logic signed [DATA_SIZE-1:0] q_out,
    output logic [COUNT_WIDTH-1:0]      sample_count
);

    localparam int IDX_W = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLE_BYTES - 1);

    if (SAMPLE_BYTES < 1 || SAMPLE_BYTES > 4) begin : g_badSampleBytes
        $error("iq_deinterleave: SAMPLE_BYTES must be in 1..4");
    end
    if (SAMPLE_BYTES * BYTE + BITS > DATA_SIZE) begin : g_badWidth
        $error("iq_deinterleave: SAMPLE_BYTES*BYTE + BITS exceeds DATA_SIZE");
    end

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            byteIdx_q, byteIdx_d;
    logic                        outValid_q, outValid_d;
    logic signed [DATA_SIZE-1:0] iOut_q, iOut_d;
    logic signed [DATA_SIZE-1:0] qOut_q, qOut_d;
    logic [COUNT_WIDTH-1:0]      sampleCount_q, sampleCount_d;

    logic                        lastByte;
    logic                        finalByte;
    logic                        popEn;
    logic                        writeEn;
    logic                        loadFirst;
    logic                        loadSecond;
    logic                        iLoad;
    logic                        qLoad;
    logic signed [DATA_SIZE-1:0] iSample;
    logic signed [DATA_SIZE-1:0] qSample;

    // Only the final byte of a frame waits for the output register to drain,
    // so a held pair is never overwritten while assembly keeps going
    assign lastByte   = (byteIdx_q == LAST_IDX);
    assign finalByte  = (state_q == S_SECOND) && lastByte;
    assign writeEn    = !reset && outValid_q && !i_out_full && !q_out_full;
    assign popEn      = !reset && !in_empty && (!finalByte || !outValid_q || writeEn);
    assign loadFirst  = popEn && (state_q == S_FIRST);
    assign loadSecond = popEn && (state_q == S_SECOND);
    assign iLoad      = (Q_FIRST != 0) ? loadSecond : loadFirst;
    assign qLoad      = (Q_FIRST != 0) ? loadFirst  : loadSecond;

    iq_sample_assembler #(
        .BYTE          (BYTE),
        .SAMPLE_BYTES  (SAMPLE_BYTES),
        .DATA_SIZE     (DATA_SIZE),
        .BITS          (BITS),
        .LITTLE_ENDIAN (LITTLE_ENDIAN),
        .IDX_W         (IDX_W)
    ) u_iAssembler (
        .clock      (clock),
        .reset      (reset),
        .load_i     (iLoad),
        .byte_idx_i (byteIdx_q),
        .data_i     (data_in),
        .sample_o   (iSample)
    );

    iq_sample_assembler #(
        .BYTE          (BYTE),
        .SAMPLE_BYTES  (SAMPLE_BYTES),
        .DATA_SIZE     (DATA_SIZE),
        .BITS          (BITS),
        .LITTLE_ENDIAN (LITTLE_ENDIAN),
        .IDX_W         (IDX_W)
    ) u_qAssembler (
        .clock      (clock),
        .reset      (reset),
        .load_i     (qLoad),
        .byte_idx_i (byteIdx_q),
        .data_i     (data_in),
        .sample_o   (qSample)
    );

    // Next state: a write drains the register first, then a final-byte pop in
    // the same cycle refills it so back-to-back frames have no bubble
    always_comb begin
        state_d       = state_q;
        byteIdx_d     = byteIdx_q;
        outValid_d    = outValid_q;
        iOut_d        = iOut_q;
        qOut_d        = qOut_q;
        sampleCount_d = sampleCount_q;

        if (writeEn) begin
            outValid_d    = 1'b0;
            sampleCount_d = sampleCount_q + COUNT_WIDTH'(1);
        end

        if (popEn) begin
            if (lastByte) begin
                byteIdx_d = '0;
                if (state_q == S_FIRST) begin
                    state_d = S_SECOND;
                end else begin
                    state_d    = S_FIRST;
                    outValid_d = 1'b1;
                    iOut_d     = iSample;
                    qOut_d     = qSample;
                end
            end else begin
                byteIdx_d = byteIdx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_FIRST;
            byteIdx_q     <= '0;
            outValid_q    <= 1'b0;
            iOut_q        <= '0;
            qOut_q        <= '0;
            sampleCount_q <= '0;
        end else begin
            state_q       <= state_d;
            byteIdx_q     <= byteIdx_d;
            outValid_q    <= outValid_d;
            iOut_q        <= iOut_d;
            qOut_q        <= qOut_d;
            sampleCount_q <= sampleCount_d;
        end
    end

    assign in_rd_en     = popEn;
    assign out_wr_en    = writeEn;
    assign i_out        = iOut_q;
    assign q_out        = qOut_q;
    assign sample_count = sampleCount_q;

endmodule
